sudoku_checker: RTL and testbench



---
 rtl/sudoku_pkg.sv | 7 +
 rtl/sudoku_checker_if.sv | 16 +
 rtl/sudoku_cell_pos.sv | 28 ++
 rtl/sudoku_checker.sv | 87 ++++++++
 tb/tb_sudoku_checker.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/sudoku_pkg.sv
// sudoku_pkg: shared constants and types for the Sudoku checker
package sudoku_pkg;
  localparam int N_CELLS = 81;
  localparam int GRID_DIM = 9;
  typedef enum logic [1:0] {ERR_NONE, ERR_RANGE, ERR_CLUE, ERR_DUP} err_t;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/sudoku_checker_if.sv
// sudoku_checker_if: trigger, ROM/RAM read ports and result bundle of the checker
interface sudoku_checker_if;
  import sudoku_pkg::*;
  logic start, ROM_rd, RAM_ceb, RAM_web, busy, valid, pass;
  logic [6:0] ROM_A, RAM_A, err_idx;
  logic [7:0] ROM_Q, RAM_Q;
  err_t err_code;
  modport master (
    input start, ROM_Q, RAM_Q,
    output ROM_rd, ROM_A, RAM_ceb, RAM_web, RAM_A, busy, valid, pass, err_code, err_idx
  );
  modport slave (
    output start, ROM_Q, RAM_Q,
    input ROM_rd, ROM_A, RAM_ceb, RAM_web, RAM_A, busy, valid, pass, err_code, err_idx
  );
endinterface

// File: rtl/sudoku_cell_pos.sv
// sudoku_cell_pos: raster-order cell index with row, column and 3x3 box, no dividers
module sudoku_cell_pos (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       step,
  output logic [6:0] idx,
  output logic [3:0] r,
  output logic [3:0] c,
  output logic [3:0] b
);
  logic [1:0] band, stack, sub_r, sub_c;
  logic wrap;
  assign wrap = c == 4'd8;
  assign b = {1'b0, band, 1'b0} + {2'b0, band} + {2'b0, stack};
  always_ff @(posedge clk or posedge rst)
    if (rst) {idx, r, c, band, stack, sub_r, sub_c} <= '0;
    else if (clear) {idx, r, c, band, stack, sub_r, sub_c} <= '0;
    else if (step) begin
      idx <= idx + 7'd1;
      c <= wrap ? 4'd0 : c + 4'd1;
      r <= wrap ? r + 4'd1 : r;
      sub_c <= sub_c == 2'd2 ? 2'd0 : sub_c + 2'd1;
      stack <= wrap ? 2'd0 : sub_c == 2'd2 ? stack + 2'd1 : stack;
      sub_r <= !wrap ? sub_r : sub_r == 2'd2 ? 2'd0 : sub_r + 2'd1;
      band <= wrap && sub_r == 2'd2 ? band + 2'd1 : band;
    end
endmodule

// File: rtl/sudoku_checker.sv
// sudoku_checker: scans solved grid against clues, reports first range/clue/duplicate error
module sudoku_checker import sudoku_pkg::*; (
  input logic clk,
  input logic rst,
  sudoku_checker_if.master bus
);
  state_t state, state_nx;
  err_t err_code, cell_err;
  logic [6:0] err_idx, idx;
  logic [3:0] r, c, b, vi;
  logic [7:0] v, g;
  logic start_d, rise, scan, clr, last, range_err, clue_err, dup_err;
  logic [GRID_DIM-1:0] row_mask [GRID_DIM];
  logic [GRID_DIM-1:0] col_mask [GRID_DIM];
  logic [GRID_DIM-1:0] box_mask [GRID_DIM];

  sudoku_cell_pos u_pos (.clk(clk), .rst(rst), .clear(clr), .step(scan), .idx(idx), .r(r), .c(c), .b(b));

  assign rise = bus.start & ~start_d;
  assign scan = state == SCAN;
  assign clr = rise & ~scan;
  assign last = idx == 7'(N_CELLS - 1);
  assign v = bus.RAM_Q;
  assign g = bus.ROM_Q;
  assign vi = v[3:0] - 4'd1;

  always_comb begin
    range_err = v == 8'd0 || v > 8'd9;
    clue_err = g != 8'd0 && v != g;
    dup_err = row_mask[r][vi] | col_mask[c][vi] | box_mask[b][vi];
    cell_err = range_err ? ERR_RANGE : clue_err ? ERR_CLUE : dup_err ? ERR_DUP : ERR_NONE;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      start_d <= 1'b0;
    end else begin
      state <= state_nx;
      start_d <= bus.start;
    end

  always_comb begin
    state_nx = state;
    if (scan) state_nx = last ? DONE : SCAN;
    else if (rise) state_nx = SCAN;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      err_code <= ERR_NONE;
      err_idx <= '0;
    end else if (clr) begin
      err_code <= ERR_NONE;
      err_idx <= '0;
    end else if (scan && err_code == ERR_NONE && cell_err != ERR_NONE) begin
      err_code <= cell_err;
      err_idx <= idx;
    end

  // masks record every in-range value, even from an erroring cell
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      row_mask <= '{default: '0};
      col_mask <= '{default: '0};
      box_mask <= '{default: '0};
    end else if (clr) begin
      row_mask <= '{default: '0};
      col_mask <= '{default: '0};
      box_mask <= '{default: '0};
    end else if (scan && !range_err) begin
      row_mask[r][vi] <= 1'b1;
      col_mask[c][vi] <= 1'b1;
      box_mask[b][vi] <= 1'b1;
    end

  assign bus.ROM_rd = scan;
  assign bus.RAM_ceb = scan;
  assign bus.RAM_web = 1'b1;
  assign bus.ROM_A = scan ? idx : '0;
  assign bus.RAM_A = scan ? idx : '0;
  assign bus.busy = scan;
  assign bus.valid = state == DONE;
  assign bus.pass = state == DONE && err_code == ERR_NONE;
  assign bus.err_code = err_code;
  assign bus.err_idx = err_idx;
endmodule

// File: tb/tb_sudoku_checker.sv
// tb_sudoku_checker: scoreboard bench for the Sudoku checker with ROM/RAM models
module tb_sudoku_checker;
  import sudoku_pkg::*;
  typedef struct packed {logic pass; logic [1:0] code; logic [6:0] idx;} res_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rom [81];
  logic [7:0] ram [81];
  res_t sb [$];
  int n_chk = 0;
  int n_pass = 0;

  sudoku_checker_if bus ();
  sudoku_checker dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  assign bus.ROM_Q = rom[bus.ROM_A];
  assign bus.RAM_Q = ram[bus.RAM_A];

  task automatic load_grid(input bit clues);
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) begin
        ram[r*9+c] = 8'((r*3 + r/3 + c) % 9 + 1);
        rom[r*9+c] = (clues && (r*9+c) % 3 == 0) ? ram[r*9+c] : 8'd0;
      end
  endtask

  task automatic kick(output int nb, output int fb, output int vc);
    nb = 0; fb = 0; vc = 0;
    bus.start = 1'b0;
    @(negedge clk); @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= 200 && vc == 0; k++) begin
      @(negedge clk);
      if (bus.busy) begin nb++; if (fb == 0) fb = k; end
      if (bus.valid) vc = k;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    load_grid(0);
    @(negedge clk);
    n_chk++;
    if ({bus.busy, bus.valid, bus.pass, bus.ROM_rd, bus.RAM_ceb, bus.RAM_web} !== 6'b000001)
      $display("FAIL reset_ctrl: busy/valid/pass/rd/ceb/web=%b want 000001",
               {bus.busy, bus.valid, bus.pass, bus.ROM_rd, bus.RAM_ceb, bus.RAM_web});
    else n_pass++;
    n_chk++;
    if ({bus.ROM_A, bus.RAM_A, bus.err_code, bus.err_idx} !== 23'd0)
      $display("FAIL reset_data: ROM_A=%0d RAM_A=%0d code=%0d idx=%0d want all 0",
               bus.ROM_A, bus.RAM_A, bus.err_code, bus.err_idx);
    else n_pass++;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_chk++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0)
      $display("FAIL idle_no_start: busy=%b valid=%b want 0 0", bus.busy, bus.valid);
    else n_pass++;
  endtask

  task automatic test_pass();
    int nb, fb, vc;
    res_t got, want;
    load_grid(1);
    sb.push_back({1'b1, 2'd0, 7'd0});
    kick(nb, fb, vc);
    n_chk++;
    if (fb !== 1) $display("FAIL pass_busy_first: got cycle %0d want 1", fb); else n_pass++;
    n_chk++;
    if (nb !== 81) $display("FAIL pass_busy_len: got %0d want 81", nb); else n_pass++;
    n_chk++;
    if (vc !== 82) $display("FAIL pass_latency: valid at %0d want 82", vc); else n_pass++;
    got = {bus.pass, bus.err_code, bus.err_idx};
    want = sb.pop_front();
    n_chk++;
    if (vc == 0 || got !== want)
      $display("FAIL pass_result: got %b/%0d/%0d want %b/%0d/%0d", got.pass, got.code, got.idx, want.pass, want.code, want.idx);
    else n_pass++;
  endtask

  task automatic test_held_high();
    bit seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.busy) seen = 1;
    end
    n_chk++;
    if (seen || bus.valid !== 1'b1 || bus.pass !== 1'b1)
      $display("FAIL held_high: busy_seen=%0b valid=%b pass=%b want 0 1 1", seen, bus.valid, bus.pass);
    else n_pass++;
  endtask

  task automatic test_range();
    int nb, fb, vc;
    res_t got, want;
    load_grid(1);
    ram[40] = 8'd0;
    sb.push_back({1'b0, 2'd1, 7'd40});
    kick(nb, fb, vc);
    got = {bus.pass, bus.err_code, bus.err_idx};
    want = sb.pop_front();
    n_chk++;
    if (vc == 0 || got !== want)
      $display("FAIL range_result: got %b/%0d/%0d want %b/%0d/%0d", got.pass, got.code, got.idx, want.pass, want.code, want.idx);
    else n_pass++;
  endtask

  task automatic test_clue();
    int nb, fb, vc;
    res_t got, want;
    load_grid(0);
    rom[5] = 8'd7;
    ram[5] = 8'd3;
    sb.push_back({1'b0, 2'd2, 7'd5});
    kick(nb, fb, vc);
    got = {bus.pass, bus.err_code, bus.err_idx};
    want = sb.pop_front();
    n_chk++;
    if (vc == 0 || got !== want)
      $display("FAIL clue_result: got %b/%0d/%0d want %b/%0d/%0d", got.pass, got.code, got.idx, want.pass, want.code, want.idx);
    else n_pass++;
  endtask

  task automatic test_dup_col();
    int nb, fb, vc;
    res_t got, want;
    load_grid(0);
    ram[0] = 8'd2;
    ram[1] = 8'd1;
    sb.push_back({1'b0, 2'd3, 7'd27});
    kick(nb, fb, vc);
    got = {bus.pass, bus.err_code, bus.err_idx};
    want = sb.pop_front();
    n_chk++;
    if (vc == 0 || got !== want)
      $display("FAIL dup_col_result: got %b/%0d/%0d want %b/%0d/%0d", got.pass, got.code, got.idx, want.pass, want.code, want.idx);
    else n_pass++;
  endtask

  task automatic test_first_error();
    int nb, fb, vc;
    res_t got, want;
    load_grid(0);
    ram[3] = 8'd1;
    ram[12] = 8'd0;
    sb.push_back({1'b0, 2'd3, 7'd3});
    kick(nb, fb, vc);
    got = {bus.pass, bus.err_code, bus.err_idx};
    want = sb.pop_front();
    n_chk++;
    if (vc == 0 || got !== want)
      $display("FAIL first_error_result: got %b/%0d/%0d want %b/%0d/%0d", got.pass, got.code, got.idx, want.pass, want.code, want.idx);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nb = 0;
    int vc = 0;
    res_t got, want;
    load_grid(1);
    sb.push_back({1'b1, 2'd0, 7'd0});
    bus.start = 1'b0;
    @(negedge clk); @(negedge clk);
    bus.start = 1'b1;
    for (int k = 1; k <= 200 && vc == 0; k++) begin
      @(negedge clk);
      if (k == 20) bus.start = 1'b0;
      if (k == 22) bus.start = 1'b1;
      if (bus.busy) nb++;
      if (bus.valid) vc = k;
    end
    n_chk++;
    if (nb !== 81 || vc !== 82)
      $display("FAIL b2b_timing: busy=%0d valid_at=%0d want 81 82", nb, vc);
    else n_pass++;
    got = {bus.pass, bus.err_code, bus.err_idx};
    want = sb.pop_front();
    n_chk++;
    if (vc == 0 || got !== want)
      $display("FAIL b2b_result: got %b/%0d/%0d want %b/%0d/%0d", got.pass, got.code, got.idx, want.pass, want.code, want.idx);
    else n_pass++;
  endtask

  task automatic test_rst_mid();
    bit seen = 0;
    load_grid(1);
    bus.start = 1'b0;
    @(negedge clk); @(negedge clk);
    bus.start = 1'b1;
    repeat (30) @(negedge clk);
    n_chk++;
    if (bus.busy !== 1'b1) $display("FAIL rst_mid_busy: busy=%b want 1", bus.busy); else n_pass++;
    rst = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); @(negedge clk);
    n_chk++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.err_code !== ERR_NONE)
      $display("FAIL rst_mid_clear: busy=%b valid=%b code=%0d want 0 0 0", bus.busy, bus.valid, bus.err_code);
    else n_pass++;
    rst = 1'b0;
    repeat (120) begin
      @(negedge clk);
      if (bus.busy || bus.valid) seen = 1;
    end
    n_chk++;
    if (seen || sb.size() != 0)
      $display("FAIL rst_mid_no_result: activity=%0b pending=%0d want 0 0", seen, sb.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_held_high();
    test_range();
    test_clue();
    test_dup_col();
    test_first_error();
    test_back_to_back();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
